sha256_compress: RTL and testbench

Iterative SHA-256 compression engine: accepts one 512-bit padded message block and computes one round per clock over 64 rounds, then adds the result into the chaining value. It owns the working registers a..h that feed the choice, majority and Σ functions, and the 16-word message-schedule window. It sits between the host-side block loader and the digest output register.

---
 rtl/sha256_pkg.sv | 73 +++++++
 rtl/sha256_round_logic.sv | 30 +++
 rtl/sha256_compress.sv | 131 +++++++++++++
 tb/tb_sha256_compress.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, round constants, initial hash value and bitwise round functions.
// Used by sha256_compress (optional multi-block chaining via SHA256_CHAIN_EN) and sha256_round_logic.
package sha256_pkg;

    typedef logic [31:0] word_t;

    // Field a sits in the most significant word, so the struct lines up with H0..H7 packing.
    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } work_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t big_sigma0(input word_t x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round_logic.sv
// One combinational SHA-256 round: working variables a..h plus W_t and K_t in,
// next a..h out.
module sha256_round_logic
    import sha256_pkg::*;
(
    input  work_t cur,
    input  word_t w_t,
    input  word_t k_t,
    output work_t nxt
);

    word_t t1_s;
    word_t t2_s;

    // Round temporaries and the a..h rotation.
    always_comb begin
        t1_s  = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k_t + w_t;
        t2_s  = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
        nxt   = cur;
        nxt.h = cur.g;
        nxt.g = cur.f;
        nxt.f = cur.e;
        nxt.e = cur.d + t1_s;
        nxt.d = cur.c;
        nxt.c = cur.b;
        nxt.b = cur.a;
        nxt.a = t1_s + t2_s;
    end

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression, one round per clock, 66-cycle latency START->DONE.
// Define SHA256_CHAIN_EN to add the FIRST port and chain from the previous DIGEST.
module sha256_compress
    import sha256_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [511:0] BLOCK,
`ifdef SHA256_CHAIN_EN
    input  logic         FIRST,
`endif
    output logic         BUSY,
    output logic         DONE,
    output logic [255:0] DIGEST
);

    state_t         state_r;
    state_t         state_s;
    logic [5:0]     t_r;
    word_t          win_r [0:15];
    work_t          work_r;
    work_t          work_nxt_s;
    logic [255:0]   hin_r;
    logic [255:0]   init_s;
    logic [255:0]   sum_s;
    word_t          w_new_s;

    sha256_round_logic u_round (
        .cur (work_r),
        .w_t (win_r[0]),
        .k_t (K[t_r]),
        .nxt (work_nxt_s)
    );

    // Next-state logic for the IDLE/ROUND/FINAL sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (START) begin
                    state_s = ROUND;
                end else begin
                    state_s = IDLE;
                end
            end
            ROUND: begin
                if (t_r == 6'd63) begin
                    state_s = FINAL;
                end else begin
                    state_s = ROUND;
                end
            end
            FINAL:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Chaining source for a newly accepted block.
    always_comb begin
`ifdef SHA256_CHAIN_EN
        if (FIRST) begin
            init_s = IV;
        end else begin
            init_s = DIGEST;
        end
`else
        init_s = IV;
`endif
    end

    // Schedule word 16 ahead of window[0]; computing it every round keeps W_t = window[0] always.
    always_comb begin
        w_new_s = small_sigma1(win_r[14]) + win_r[9] + small_sigma0(win_r[1]) + win_r[0];
    end

    // Per-word mod-2^32 feed-forward into the chaining value.
    always_comb begin
        sum_s = 256'd0;
        for (int i = 0; i < 8; i++) begin
            sum_s[32*i +: 32] = hin_r[32*i +: 32] + work_r[32*i +: 32];
        end
    end

    // State, counter, schedule window, working variables and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            t_r     <= 6'd0;
            work_r  <= '0;
            hin_r   <= 256'd0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            DIGEST  <= 256'd0;
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= 32'd0;
            end
        end else begin
            state_r <= state_s;
            BUSY    <= (state_s != IDLE);
            DONE    <= (state_r == FINAL);
            case (state_r)
                IDLE: begin
                    if (START) begin
                        for (int i = 0; i < 16; i++) begin
                            win_r[i] <= BLOCK[511-32*i -: 32];
                        end
                        work_r <= work_t'(init_s);
                        hin_r  <= init_s;
                        t_r    <= 6'd0;
                    end
                end
                ROUND: begin
                    work_r <= work_nxt_s;
                    for (int i = 0; i < 15; i++) begin
                        win_r[i] <= win_r[i+1];
                    end
                    win_r[15] <= w_new_s;
                    t_r       <= t_r + 6'd1;
                end
                FINAL: begin
                    DIGEST <= sum_s;
                end
                default: begin
                    t_r <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench for sha256_compress using known FIPS 180 digests and cycle-exact timing.
module tb_sha256_compress;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [511:0] BLOCK;
`ifdef SHA256_CHAIN_EN
    logic         FIRST;
`endif
    logic         BUSY;
    logic         DONE;
    logic [255:0] DIGEST;

    int tests = 0;
    int fails = 0;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'd0};
    localparam logic [511:0] TWO_B1    = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2    = {480'd0, 32'h000001c0};

    localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    sha256_compress dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .BLOCK  (BLOCK),
`ifdef SHA256_CHAIN_EN
        .FIRST  (FIRST),
`endif
        .BUSY   (BUSY),
        .DONE   (DONE),
        .DIGEST (DIGEST)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives START for one cycle, scrambles BLOCK afterwards, optionally re-pulses START,
    // and returns the cycle count to DONE (0 on timeout) and cycles where BUSY was not 1.
    task automatic run_block(input logic [511:0] blk, input int p1, input int p2,
                             output int lat, output int busy_err);
        BLOCK    = blk;
        START    = 1'b1;
        lat      = 0;
        busy_err = 0;
        for (int n = 1; n <= 150; n++) begin
            tick();
            BLOCK = ~blk;
            START = (n == p1) || (n == p2);
            if (DONE === 1'b1) begin
                lat = n;
                break;
            end else if (BUSY !== 1'b1) begin
                busy_err++;
            end
        end
        START = 1'b0;
    endtask

    initial begin
        int lat;
        int lat2;
        int berr;
        int cnt_done;
        int cnt_busy;
        int cnt_dig;
        logic [255:0] last_dig;

        RST   = 1'b1;
        START = 1'b0;
        BLOCK = 512'd0;
`ifdef SHA256_CHAIN_EN
        FIRST = 1'b1;
`endif
        tick();
        tick();
        RST = 1'b0;
        check_int("reset_busy", int'(BUSY), 0);
        check_int("reset_done", int'(DONE), 0);
        check_vec("reset_digest", DIGEST, 256'd0);

        // Idle for 100 cycles after reset with no START.
        cnt_done = 0;
        cnt_busy = 0;
        cnt_dig  = 0;
        for (int i = 0; i < 100; i++) begin
            BLOCK = ABC_BLK;
            tick();
            if (DONE !== 1'b0) cnt_done++;
            if (BUSY !== 1'b0) cnt_busy++;
            if (DIGEST !== 256'd0) cnt_dig++;
        end
        check_int("idle_done_cycles", cnt_done, 0);
        check_int("idle_busy_cycles", cnt_busy, 0);
        check_int("idle_digest_cycles", cnt_dig, 0);

        // "abc" single block.
        run_block(ABC_BLK, 0, 0, lat, berr);
        check_int("abc_latency", lat, 66);
        check_int("abc_busy_high", berr, 0);
        check_int("abc_busy_at_done", int'(BUSY), 0);
        check_vec("abc_digest", DIGEST, ABC_DIG);

        // Empty message, accepted in the DONE cycle of "abc".
        run_block(EMPTY_BLK, 0, 0, lat, berr);
        check_int("empty_latency", lat, 66);
        check_int("empty_busy_high", berr, 0);
        check_vec("empty_digest", DIGEST, EMPTY_DIG);
        last_dig = EMPTY_DIG;

`ifdef SHA256_CHAIN_EN
        FIRST = 1'b1;
        run_block(TWO_B1, 0, 0, lat, berr);
        check_int("two_b1_busy_high", berr, 0);
        FIRST = 1'b0;
        run_block(TWO_B2, 0, 0, lat2, berr);
        FIRST = 1'b1;
        check_int("two_total_cycles", lat + lat2, 132);
        check_int("two_b2_busy_high", berr, 0);
        check_vec("two_digest", DIGEST, TWO_DIG);
        last_dig = TWO_DIG;
`endif

        // DIGEST holds and DONE is a single pulse.
        cnt_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (DONE !== 1'b0) cnt_done++;
        end
        check_int("hold_done_pulse", cnt_done, 0);
        check_vec("hold_digest", DIGEST, last_dig);

        // START pulses at C+10 and C+40 are ignored.
        run_block(ABC_BLK, 10, 40, lat, berr);
        check_int("ign_latency", lat, 66);
        check_int("ign_busy_high", berr, 0);
        check_vec("ign_digest", DIGEST, ABC_DIG);
        cnt_done = 0;
        cnt_busy = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (DONE !== 1'b0) cnt_done++;
            if (BUSY !== 1'b0) cnt_busy++;
        end
        check_int("ign_extra_done", cnt_done, 0);
        check_int("ign_extra_busy", cnt_busy, 0);

        // Reset at C+30 aborts the block.
        BLOCK = EMPTY_BLK;
        START = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            START = 1'b0;
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_int("abort_busy", int'(BUSY), 0);
        check_int("abort_done", int'(DONE), 0);
        check_vec("abort_digest", DIGEST, 256'd0);
        cnt_done = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (DONE !== 1'b0) cnt_done++;
        end
        check_int("abort_no_done", cnt_done, 0);

        run_block(ABC_BLK, 0, 0, lat, berr);
        check_int("post_abort_latency", lat, 66);
        check_vec("post_abort_digest", DIGEST, ABC_DIG);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
